// File: rtl/mk14_vdu_ram.sv
`default_nettype none
// ============================================================================
// Module      : mk14_vdu_ram
// Description : MK14 VDU display memory. Single-port RAM shared between the
//               VDU read port (always priority) and a req/ack CPU bus port.
//               Clears the whole window to FILL after every reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mk14_vdu_ram #(
    parameter logic [15:0] BASE_ADDR = 16'h0200,
    parameter int          DEPTH     = 512,
    parameter logic [7:0]  FILL      = 8'h00
) (
    input  logic        clk_pix,
    input  logic        rst_pix,
    input  logic        read_en,
    input  logic [15:0] read_addr,
    output logic [7:0]  display_data,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic        busy
);

    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW-1:0]  c_LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_clr_idx;
    logic [AW-1:0]   w_clr_idx_nxt;

    // RAM port controls for this cycle
    logic            w_ram_we;
    logic [AW-1:0]   w_ram_idx;
    logic [7:0]      w_ram_wdata;
    logic [7:0]      r_mem [DEPTH];
    logic [7:0]      r_ram_q;

    // Output update requests: load = value changes, from_ram = take RAM data
    logic            w_vdu_load;
    logic            w_vdu_from_ram;
    logic            w_cpu_load;
    logic            w_cpu_from_ram;

    // Output holding registers and RAM-source selects
    logic            r_disp_sel_ram;
    logic [7:0]      r_disp_hold;
    logic            r_cpu_sel_ram;
    logic [7:0]      r_cpu_hold;

    logic            w_vdu_hit;
    logic            w_cpu_hit;

    assign w_vdu_hit = (read_addr[15:AW] == BASE_ADDR[15:AW]);
    assign w_cpu_hit = (cpu_addr[15:AW]  == BASE_ADDR[15:AW]);

    // Arbitration and next-state: clear sweep, then VDU first, CPU only from IDLE
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_idx_nxt  = r_clr_idx;
        w_ram_we       = 1'b0;
        w_ram_idx      = '0;
        w_ram_wdata    = FILL;
        w_vdu_load     = 1'b0;
        w_vdu_from_ram = 1'b0;
        w_cpu_load     = 1'b0;
        w_cpu_from_ram = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_ram_we      = 1'b1;
                w_ram_idx     = r_clr_idx;
                w_ram_wdata   = FILL;
                w_clr_idx_nxt = r_clr_idx + 1'b1;
                // VDU reads during the clear return zero without touching RAM
                w_vdu_load    = read_en;
                if (r_clr_idx == c_LAST_IDX) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE, S_ACK: begin
                // ACK always lasts one cycle and never grants the CPU
                if (r_state == S_ACK) begin
                    w_state_nxt = S_IDLE;
                end
                if (read_en) begin
                    w_vdu_load     = 1'b1;
                    w_vdu_from_ram = w_vdu_hit;
                    w_ram_idx      = read_addr[AW-1:0];
                end else if (cpu_req && (r_state == S_IDLE)) begin
                    w_state_nxt = S_ACK;
                    w_ram_idx   = cpu_addr[AW-1:0];
                    w_ram_wdata = cpu_wdata;
                    w_cpu_load  = ~cpu_we;
                    if (w_cpu_hit) begin
                        w_ram_we       = cpu_we;
                        w_cpu_from_ram = ~cpu_we;
                    end
                end
            end
            default: begin
                w_state_nxt   = S_CLEAR;
                w_clr_idx_nxt = '0;
            end
        endcase
    end

    // State and clear-index registers
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    // Single-port RAM with registered read; a reset cycle abandons any write
    always_ff @(posedge clk_pix) begin
        if (w_ram_we && !rst_pix) begin
            r_mem[w_ram_idx] <= w_ram_wdata;
        end
        r_ram_q <= r_mem[w_ram_idx];
    end

    // Output hold registers: track the visible value, override with constants
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_disp_sel_ram <= 1'b0;
            r_disp_hold    <= 8'h00;
            r_cpu_sel_ram  <= 1'b0;
            r_cpu_hold     <= 8'h00;
        end else begin
            r_disp_sel_ram <= w_vdu_load & w_vdu_from_ram;
            r_disp_hold    <= (w_vdu_load && !w_vdu_from_ram) ? 8'h00 : display_data;
            r_cpu_sel_ram  <= w_cpu_load & w_cpu_from_ram;
            r_cpu_hold     <= (w_cpu_load && !w_cpu_from_ram) ? 8'hFF : cpu_rdata;
        end
    end

    assign display_data = r_disp_sel_ram ? r_ram_q : r_disp_hold;
    assign cpu_rdata    = r_cpu_sel_ram  ? r_ram_q : r_cpu_hold;
    assign cpu_ack      = (r_state == S_ACK);
    assign busy         = (r_state == S_CLEAR);

endmodule
`default_nettype wire

// File: doc/mk14_vdu_ram.md
# mk14_vdu_ram

Display memory for the MK14 VDU, shared between the CPU bus and the VDU read port. Serves the VDU's `read_en`/`read_addr` requests with one-cycle read data on `display_data`. Arbitrates single-port RAM access with CPU bus cycles, always giving the VDU priority. After reset it clears the whole window to a fill byte before serving the CPU.

## Interface
Parameters:
- `BASE_ADDR`, 16'h0200: first byte address of the display window. Must be aligned to `DEPTH`.
- `DEPTH`, 512: window size in bytes. Must be a power of two, between 16 and 4096.
- `FILL`, 8'h00: byte written to every location during the post-reset clear.

Ports (one clock; reset is synchronous and active-high):
- `clk_pix`, input, 1: pixel/system clock; all logic on its rising edge.
- `rst_pix`, input, 1: synchronous active-high reset.
- `read_en`, input, 1: VDU read strobe.
- `read_addr`, input, 16: VDU byte address.
- `display_data`, output, 8: VDU read data.
- `cpu_req`, input, 1: CPU access request; held high until `cpu_ack`.
- `cpu_we`, input, 1: 1 = write, 0 = read. Stable while `cpu_req` is high.
- `cpu_addr`, input, 16: CPU byte address. Stable while `cpu_req` is high.
- `cpu_wdata`, input, 8: CPU write data. Stable while `cpu_req` is high.
- `cpu_rdata`, output, 8: CPU read data; valid while `cpu_ack` is high.
- `cpu_ack`, output, 1: one-cycle completion pulse.
- `busy`, output, 1: high while the post-reset clear runs.

## Operation
- In-window test: `addr[15:log2(DEPTH)] == BASE_ADDR[15:log2(DEPTH)]`. The RAM index is `addr[log2(DEPTH)-1:0]`.
- The memory is one single-port RAM of `DEPTH` x 8 (block RAM inferable). Only one access happens per cycle.
- FSM states:
  - CLEAR: entered on reset; `clr_idx` starts at 0. Each cycle writes `FILL` at `clr_idx` and increments it. After writing index `DEPTH-1`, go to IDLE.
  - IDLE: if `read_en` is high, do the VDU read and stay in IDLE. Otherwise, if `cpu_req` is high, grant the CPU. An in-window write writes the RAM; an in-window read reads it; an out-of-window access does not touch the RAM. Go to ACK.
  - ACK: assert `cpu_ack`, then return to IDLE. No CPU grant happens in this state, so a still-high `cpu_req` is not re-served. VDU reads are still served.
- VDU reads in ACK and IDLE have priority over the CPU. The CPU waits for as long as `read_en` stays high. There is no starvation override; the VDU only reads during visible character lines.
- VDU read in CLEAR: `display_data` <= 8'h00 and the RAM is not read. `read_en` is ignored as far as RAM access goes.
- VDU read out of window: `display_data` <= 8'h00.
- CPU read out of window: `cpu_rdata` = 8'hFF. CPU write out of window: dropped, but still acked.
- `cpu_req` during CLEAR: held off, no ack, until IDLE.
- `cpu_rdata` holds its last value outside ack cycles. `display_data` holds its value until the next `read_en`.

## Timing
- Reset values:
  - `display_data` = 0, `cpu_rdata` = 0, `cpu_ack` = 0.
  - `busy` = 1; state = CLEAR, `clr_idx` = 0.
- Reset asserted mid-operation: any pending CPU access is abandoned without an ack, and the clear restarts from index 0.
- Clear length: exactly `DEPTH` cycles. `busy` falls in the first IDLE cycle, at cycle `DEPTH` after reset deasserts.
- VDU latency: `read_en` in cycle N → `display_data` valid from cycle N+1. Back-to-back reads are supported every cycle.
- CPU latency: grant in cycle G → `cpu_ack` = 1 and `cpu_rdata` valid in G+1. Minimum is 2 cycles from `cpu_req` to ack with no contention.
- A CPU write granted in cycle G is visible to a VDU read issued in cycle G+1 or later.
- Same-cycle `read_en` and `cpu_req` in IDLE: the VDU is served and the CPU grant slips to the first cycle in IDLE with `read_en` low.

## Test plan
- Reset clear: pulse `rst_pix`, then read all 512 addresses via `read_en` after `busy` falls. Required: every read = `FILL`. `busy` high for exactly 512 cycles.
- CPU write then VDU read: write 8'h41 to 16'h0205 with no contention. Required: `cpu_ack` 2 cycles after `cpu_req` rises. A `read_en` at 16'h0205 in the ack cycle returns 8'h41 next cycle.
- Contention: hold `read_en` high for 10 cycles while a CPU read of 16'h0205 is pending. Required: no ack during those 10 cycles, ack 2 cycles after `read_en` drops, `cpu_rdata` = 8'h41. The VDU stream is uninterrupted.
- Out of window: CPU write 8'h55 to 16'h0400, then CPU read 16'h0400. Required: both acked, read returns 8'hFF. VDU read at 16'h0400 returns 8'h00. Address 16'h0000 is unchanged.
- Reset mid-access: assert `rst_pix` in a grant cycle. Required: no `cpu_ack`, `busy` = 1 the next cycle, and the clear restarts with `clr_idx` = 0.
- Held request: keep `cpu_req` high for 6 cycles after the ack. Required: exactly one ack per grant, with re-grants no more often than every 2 cycles.
